// File: rtl/spm_pkg.sv
// Shared types and helpers for the serial carry-save multiplier.
package spm_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FIX, HOLD} spm_state_t;

  // RUN lasts 2*width cycles; one spare bit keeps the terminal count well inside range.
  function automatic int spm_cnt_w(input int width);
    return $clog2(2 * width) + 1;
  endfunction

  // Magnitude of a width-bit operand; -2^(width-1) maps to 2^(width-1), which still fits unsigned.
  function automatic logic [63:0] spm_abs(input logic [63:0] value, input int width,
                                          input logic signed_mode);
    logic [63:0] mask;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    if (signed_mode && value[width-1])
      return (~value + 64'd1) & mask;
    return value & mask;
  endfunction

endpackage

// File: rtl/spm_csa_cell.sv
// One bit of the carry-save chain: full-adds the partial product, upstream sum and own carry.
// Sum and carry are registered; clr empties the cell before a new operation.
module spm_csa_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic a_bit,
  input  logic b_ser,
  input  logic sum_in,
  output logic sum_q
);

  logic r_sum;
  logic r_carry;
  logic w_pp;
  logic w_sum_d;
  logic w_carry_d;

  assign w_pp      = a_bit & b_ser;
  assign w_sum_d   = w_pp ^ sum_in ^ r_carry;
  assign w_carry_d = (w_pp & sum_in) | (w_pp & r_carry) | (sum_in & r_carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= 1'b0;
      r_carry <= 1'b0;
    end else if (clr) begin
      r_sum   <= 1'b0;
      r_carry <= 1'b0;
    end else if (en) begin
      r_sum   <= w_sum_d;
      r_carry <= w_carry_d;
    end
  end

  assign sum_q = r_sum;

endmodule

// File: rtl/spm_serial_mult.sv
// Serial-parallel WIDTH x WIDTH multiplier (unsigned or two's complement), B fed LSB first.
// Result after 2*WIDTH RUN cycles plus one sign-fix cycle; held in HOLD until out_ready.
module spm_serial_mult
  import spm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int PW = 2 * WIDTH;
  localparam int CNT_W = spm_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PW - 1);

  spm_state_t r_state;
  spm_state_t w_state_nxt;

  logic [WIDTH-1:0] r_a_mag;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_neg;
  logic [CNT_W-1:0] r_cnt;
  logic [PW-2:0]    r_prod;
  logic [PW-1:0]    r_p;

  logic             w_accept;
  logic             w_run;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_sum_q;
  logic [WIDTH-1:0] w_sum_in;
  logic [PW-1:0]    w_full;
  logic [PW-1:0]    w_fixed;

  assign w_accept = (r_state == IDLE) & start;
  assign w_run    = (r_state == RUN);
  assign w_a_mag  = WIDTH'(spm_abs(64'(a), WIDTH, signed_mode));
  assign w_b_mag  = WIDTH'(spm_abs(64'(b), WIDTH, signed_mode));

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    if (i == WIDTH - 1) begin : g_top
      assign w_sum_in[i] = 1'b0;
    end else begin : g_mid
      assign w_sum_in[i] = w_sum_q[i+1];
    end
    spm_csa_cell u_cell (
      .clk    (clk),
      .rst_n  (rst),
      .clr    (w_accept),
      .en     (w_run),
      .a_bit  (r_a_mag[i]),
      .b_ser  (r_b_sh[0]),
      .sum_in (w_sum_in[i]),
      .sum_q  (w_sum_q[i])
    );
  end

  // Cell 0's registered sum lags one cycle, so the last product bit joins in FIX.
  assign w_full  = {w_sum_q[0], r_prod};
  assign w_fixed = r_neg ? (~w_full + PW'(1)) : w_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (r_cnt == LAST) w_state_nxt = FIX;
      FIX:     w_state_nxt = HOLD;
      HOLD:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_mag <= '0;
      r_b_sh  <= '0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
      r_prod  <= '0;
      r_p     <= '0;
    end else begin
      if (w_accept) begin
        r_a_mag <= w_a_mag;
        r_b_sh  <= w_b_mag;
        r_neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        r_cnt   <= '0;
      end else if (w_run) begin
        r_b_sh <= r_b_sh >> 1;
        r_cnt  <= r_cnt + CNT_W'(1);
        if (r_cnt != '0) r_prod <= {w_sum_q[0], r_prod[PW-2:1]};
      end
      if (r_state == FIX) r_p <= w_fixed;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == HOLD);
  assign p         = r_p;

endmodule

// File: tb/tb_spm_serial_mult.sv
// Directed and randomised checks of spm_serial_mult at WIDTH=8.
module tb_spm_serial_mult;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           signed_mode;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           in_ready;
  logic [2*W-1:0] p;
  logic           out_valid;
  logic           out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  spm_serial_mult #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .in_ready    (in_ready),
    .p           (p),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Latency counts the acceptance edge as 1; -1 means out_valid never came.
  task automatic run_mult(input logic [7:0] ia, input logic [7:0] ib, input logic ism,
                          input int busy_at, output logic [15:0] op, output int lat);
    a = ia; b = ib; signed_mode = ism; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int c = 2; c <= 60; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (out_valid) begin
        lat = c;
        break;
      end
      if (c == busy_at) begin
        start = 1'b1; a = 8'h03; b = 8'h03;
      end
    end
    op = p;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++;
    if (p !== 16'h0000) begin n_fail++; $display("FAIL reset_p: got %h want 0000", p); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL reset_release: in_ready/out_valid got %b want 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_unsigned();
    logic [15:0] got;
    int lat;
    run_mult(8'hFF, 8'hFF, 1'b0, 0, got, lat);
    n_tests++;
    if (lat !== 18) begin n_fail++; $display("FAIL unsigned_latency: got %0d want 18", lat); end
    n_tests++;
    if (got !== 16'hFE01) begin n_fail++; $display("FAIL unsigned_ff_ff: got %h want fe01", got); end
    @(posedge clk); #1;
    n_tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL unsigned_consume: in_ready/out_valid got %b want 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_signed();
    logic [7:0]  ta [3] = '{8'h80, 8'hFF, 8'h00};
    logic [7:0]  tb [3] = '{8'h80, 8'h05, 8'h80};
    logic [15:0] te [3] = '{16'h4000, 16'hFFFB, 16'h0000};
    logic [15:0] got;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_mult(ta[i], tb[i], 1'b1, 0, got, lat);
      n_tests++;
      if (got !== te[i] || lat !== 18) begin
        n_fail++;
        $display("FAIL signed_%0d: a=%h b=%h got p=%h lat=%0d want p=%h lat=18", i, ta[i], tb[i], got, lat, te[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] got;
    int lat;
    int seen;
    out_ready = 1'b0;
    run_mult(8'h0D, 8'h0B, 1'b0, 0, got, lat);
    n_tests++;
    if (got !== 16'h008F || lat !== 18) begin
      n_fail++; $display("FAIL bp_result: got p=%h lat=%0d want p=008f lat=18", got, lat);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin start = 1'b1; a = 8'h55; b = 8'h66; end
      @(posedge clk); #1;
      start = 1'b0;
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || p !== 16'h008F) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got out_valid=%b in_ready=%b p=%h want 1 0 008f", i, out_valid, in_ready, p);
      end
    end
    // start together with out_ready in HOLD must not be taken
    out_ready = 1'b1; start = 1'b1; a = 8'h02; b = 8'h02;
    @(posedge clk); #1;
    start = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || p !== 16'h008F) begin
      n_fail++;
      $display("FAIL bp_release: got out_valid=%b in_ready=%b p=%h want 0 1 008f", out_valid, in_ready, p);
    end
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) seen++;
    end
    n_tests++;
    if (seen !== 0) begin n_fail++; $display("FAIL bp_start_ignored: busy cycles got %0d want 0", seen); end
  endtask

  task automatic test_busy_start();
    logic [15:0] got;
    int lat;
    int seen;
    run_mult(8'h12, 8'h34, 1'b0, 5, got, lat);
    n_tests++;
    if (got !== 16'h03A8 || lat !== 18) begin
      n_fail++; $display("FAIL busy_result: got p=%h lat=%0d want p=03a8 lat=18", got, lat);
    end
    @(posedge clk); #1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) seen++;
    end
    n_tests++;
    if (seen !== 0) begin n_fail++; $display("FAIL busy_second_valid: busy cycles got %0d want 0", seen); end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] got;
    int lat;
    a = 8'h12; b = 8'h34; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || p !== 16'h0000) begin
      n_fail++;
      $display("FAIL midrun_reset: got in_ready=%b out_valid=%b p=%h want 1 0 0000", in_ready, out_valid, p);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_mult(8'h07, 8'h09, 1'b0, 0, got, lat);
    n_tests++;
    if (got !== 16'h003F || lat !== 18) begin
      n_fail++; $display("FAIL midrun_fresh: got p=%h lat=%0d want p=003f lat=18", got, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random_sweep();
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        rs;
    logic [15:0] xa;
    logic [15:0] xb;
    logic [15:0] exp_p;
    logic [15:0] got;
    int lat;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom_range(0, 1));
      xa = rs ? {{8{ra[7]}}, ra} : {8'h00, ra};
      xb = rs ? {{8{rb[7]}}, rb} : {8'h00, rb};
      exp_p = xa * xb;
      run_mult(ra, rb, rs, 0, got, lat);
      n_tests++;
      if (got !== exp_p || lat !== 18) begin
        n_fail++;
        $display("FAIL sweep_%0d: a=%h b=%h s=%b got p=%h lat=%0d want p=%h lat=18", i, ra, rb, rs, got, lat, exp_p);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_busy_start();
    test_reset_mid_run();
    test_random_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spm_serial_mult.md
Name: spm_serial_mult

Overview:
- Parametrised successor of the fixed-width spm carry-save multiplier.
- Multiplies a WIDTH-bit parallel operand A by a WIDTH-bit operand B. B is consumed serially, LSB first, through a chain of WIDTH carry-save cells.
- Supports unsigned or two's-complement mode per operation, a start/ready input handshake, and a valid/ready output handshake with backpressure.
- Sits alongside the existing spm partitions as the reusable multiplier core; its per-cell CSA outputs remain equivalence-checkable.

Parameters:
- WIDTH, 8, operand width in bits (>= 2). Product width is 2*WIDTH.

Ports:
- clk, in, 1, single clock; all flops rising-edge.
- rst, in, 1, reset; asynchronous assert, active-low (0 = reset); deassertion is synchronous to clk.
- start, in, 1, request; accepted only when in_ready=1.
- signed_mode, in, 1, sampled with start: 1 = two's complement, 0 = unsigned.
- a, in, WIDTH, parallel operand; sampled on start acceptance.
- b, in, WIDTH, serial operand; sampled on start acceptance.
- in_ready, out, 1, high only in IDLE.
- p, out, 2*WIDTH, product; stable from out_valid rise until the next start acceptance.
- out_valid, out, 1, product valid.
- out_ready, in, 1, consumer accepts p when out_valid & out_ready.

Behaviour:
- Reset, asynchronous and active-low: state=IDLE, in_ready=1, out_valid=0, p=0. All CSA sum/carry flops, shift registers and counter clear to 0.
- FSM states are IDLE, RUN, FIX and HOLD.
- IDLE -> RUN on start. Action: latch |a| and |b| as magnitudes (equal to a and b when signed_mode=0), latch neg = signed_mode & (a[W-1]^b[W-1]), clear the CSA chain, set cnt=0.
- RUN lasts exactly 2*WIDTH cycles.
  - Cycle k feeds bit k of |b| into the chain; bits k >= WIDTH feed 0.
  - Each cell i computes full-add(|a|[i] & bser, sum from cell i+1, own carry). Cell WIDTH-1 takes 0 as its upstream sum.
  - Cell 0's sum is the product bit k and shifts into the product register from the MSB side.
  - cnt is clog2(2*WIDTH)+1 bits wide; RUN -> FIX when cnt == 2*WIDTH-1.
- FIX (1 cycle): p <= neg ? (~prod + 1) mod 2^(2W) : prod.
- FIX -> HOLD: out_valid=1.
- HOLD: p and out_valid hold while out_ready=0. On out_valid & out_ready, go to IDLE and drop out_valid the next cycle.
- Latency: start accepted at edge T -> out_valid high after edge T+2*WIDTH+1, i.e. 2*WIDTH+2 cycles after acceptance.
- Throughput: one product per 2*WIDTH+3 cycles minimum (the extra cycle is HOLD->IDLE).
- start while in_ready=0 is ignored entirely; it is not queued.
- start and out_ready asserted together in HOLD: out_ready is taken, start is ignored (in_ready is 0).
- p is not cleared on return to IDLE; it changes only in FIX.
- Boundary, signed mode with a = b = -2^(W-1): magnitudes are 2^(W-1) and fit in W unsigned bits; result is +2^(2W-2); no overflow.
- Boundary, signed mode with a zero operand: result 0 even when neg=1, since two's complement of 0 is 0.
- Reset mid-RUN or mid-HOLD: immediate return to IDLE; outputs take reset values; the in-flight result is discarded.

Decomposition:
- Package spm_pkg holds:
  - state enum spm_state_t {IDLE, RUN, FIX, HOLD};
  - function spm_abs(value, signed_mode);
  - constant helper for counter width CNT_W(WIDTH).
- Sub-module spm_csa_cell: one bit of the chain. Inputs: a_bit, b_ser, sum_in. Holds registered sum and carry with async active-low rst and a synchronous clear. Instantiated WIDTH times in a generate loop.

Test Plan (WIDTH=8):
- Unsigned: signed_mode=0, a=0xFF, b=0xFF, start -> out_valid exactly 18 cycles after acceptance, p=0xFE01.
- Signed extremes: signed_mode=1, a=0x80, b=0x80 -> p=0x4000. Then a=0xFF (-1), b=0x05 -> p=0xFFFB. Then a=0x00, b=0x80 -> p=0x0000.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> p and out_valid stable, in_ready=0. Raise out_ready -> out_valid low next cycle, in_ready high.
- Busy start ignored: second start with a=0x03, b=0x03 pulsed mid-RUN of 0x12*0x34 -> only p=0x03A8 produced; no second out_valid.
- Reset mid-RUN: drop rst at RUN cycle 5 -> same cycle in_ready=1, out_valid=0, p=0. Then a fresh 0x07*0x09 -> p=0x003F.
- Randomised sweep against a reference model: 1000 random a/b/signed_mode triples -> p matches a*b (sign-interpreted) mod 2^16, latency always 18 cycles.
